// File: rtl/mul8x8_pkg.sv
// -----------------------------------------------------------------------------
// mul8x8_pkg
// Shared definitions for the unsigned 8x8 approximate multiplier datapath.
// Each partial-product row arrives from the half-adder/OR front end as a
// t vector (sum bits, bit i weight 2^i) and a b vector (carry bits, bit i
// weight 2^(i+B_SHIFT)). Row k carries weight 4^k (ROW_SHIFT bits per row).
// -----------------------------------------------------------------------------
package mul8x8_pkg;

    localparam int ROW_T_W   = 9;
    localparam int ROW_B_W   = 7;
    localparam int NUM_ROWS  = 4;
    localparam int PROD_W    = 16;
    localparam int B_SHIFT   = 2;
    localparam int ROW_SHIFT = 2;

    typedef struct packed {
        logic [ROW_T_W-1:0] t;
        logic [ROW_B_W-1:0] b;
    } row_t;

endpackage

// File: rtl/ha_row_value.sv
// -----------------------------------------------------------------------------
// ha_row_value
// Combinational reconstruction of one partial-product row: value = t + (b << 2).
// Ports:
//   row   - t/b pair of one half-adder array row
//   value - reconstructed row value, zero-extended to ROW_W bits
// -----------------------------------------------------------------------------
module ha_row_value
    import mul8x8_pkg::*;
#(
    parameter int ROW_W = 10
) (
    input  row_t             row,
    output logic [ROW_W-1:0] value
);

    assign value = ROW_W'(row.t) + (ROW_W'(row.b) << B_SHIFT);

endmodule

// File: rtl/ha_array_reducer.sv
// -----------------------------------------------------------------------------
// ha_array_reducer
// Two-stage pipelined final summation for the 8x8 approximate multiplier.
// Stage 1 merges rows pairwise, stage 2 forms the product. Valid/ready on both
// sides with full-throughput back-pressure; latency 2 cycles.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid / in_ready   - input handshake (in_ready depends on out_ready only)
//   ha_array_k_t/_b       - row k sum bits (9) and carry bits (7), k = 0..3
//   out_valid / out_ready - output handshake
//   prod                  - product modulo 2^PROD_W
//   prod_ovf              - true sum reached 2^PROD_W (illegal row patterns)
// -----------------------------------------------------------------------------
module ha_array_reducer
    import mul8x8_pkg::row_t;
    import mul8x8_pkg::NUM_ROWS;
    import mul8x8_pkg::ROW_SHIFT;
#(
    parameter int PROD_W = mul8x8_pkg::PROD_W,
    parameter int ROW_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        ha_array_0_t,
    input  logic [6:0]        ha_array_0_b,
    input  logic [8:0]        ha_array_1_t,
    input  logic [6:0]        ha_array_1_b,
    input  logic [8:0]        ha_array_2_t,
    input  logic [6:0]        ha_array_2_b,
    input  logic [8:0]        ha_array_3_t,
    input  logic [6:0]        ha_array_3_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] prod,
    output logic              prod_ovf
);

    // Pair sums need 13 bits: the all-ones pattern gives 1019 + 4*1019 = 5095,
    // which would wrap in 12 bits and hide the overflow indication.
    localparam int PAIR_W = ROW_W + ROW_SHIFT + 1;
    localparam int SUM_W  = PROD_W + 1;

    row_t             rows     [NUM_ROWS];
    logic [ROW_W-1:0] row_vals [NUM_ROWS];

    assign rows[0] = '{t: ha_array_0_t, b: ha_array_0_b};
    assign rows[1] = '{t: ha_array_1_t, b: ha_array_1_b};
    assign rows[2] = '{t: ha_array_2_t, b: ha_array_2_b};
    assign rows[3] = '{t: ha_array_3_t, b: ha_array_3_b};

    for (genvar k = 0; k < NUM_ROWS; k++) begin : g_row
        ha_row_value #(.ROW_W(ROW_W)) u_row (
            .row   (rows[k]),
            .value (row_vals[k])
        );
    end

    logic              s1_valid;
    logic              s2_valid;
    logic [PAIR_W-1:0] pa;
    logic [PAIR_W-1:0] pb;
    logic [SUM_W-1:0]  sum;
    logic              s1_adv;
    logic              s2_adv;

    // A stage advances when it is empty or the stage downstream advances.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign sum = SUM_W'(pa) + (SUM_W'(pb) << (2 * ROW_SHIFT));

    // NOTE: every clocked block uses non-blocking assignments so all registers
    // sample pre-edge values and stage order in the source does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            prod     <= '0;
            prod_ovf <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                // Only load on real data so prod holds its last value through bubbles.
                if (s1_valid) begin
                    prod     <= sum[PROD_W-1:0];
                    prod_ovf <= sum[PROD_W];
                end
            end
        end
    end

    // NOTE: pair-sum registers carry no reset; their content is qualified by
    // s1_valid, so reset would only add fan-out on rst.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            pa <= PAIR_W'(row_vals[0]) + (PAIR_W'(row_vals[1]) << ROW_SHIFT);
            pb <= PAIR_W'(row_vals[2]) + (PAIR_W'(row_vals[3]) << ROW_SHIFT);
        end
    end

endmodule

// File: tb/tb_ha_array_reducer.sv
// -----------------------------------------------------------------------------
// tb_ha_array_reducer
// Self-checking bench for ha_array_reducer: directed weight/latency/stall/reset
// steps followed by random multiplications driven as legal row encodings.
// -----------------------------------------------------------------------------
module tb_ha_array_reducer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  t_in [4];
    logic [6:0]  b_in [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] prod;
    logic        prod_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] exp_q [$];
    logic [16:0] cur_exp;
    logic        accepted;
    logic        stall_prev;
    logic [15:0] held_prod;
    logic        held_ovf;
    logic        saw_full;
    int          n_out;

    always #5 clk = ~clk;

    ha_array_reducer dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_t (t_in[0]),
        .ha_array_0_b (b_in[0]),
        .ha_array_1_t (t_in[1]),
        .ha_array_1_b (b_in[1]),
        .ha_array_2_t (t_in[2]),
        .ha_array_2_b (b_in[2]),
        .ha_array_3_t (t_in[3]),
        .ha_array_3_b (b_in[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .prod         (prod),
        .prod_ovf     (prod_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Reference: each row is t + 4*b, row k weighted by 4^k, summed exactly.
    function automatic logic [16:0] model_sum();
        int total = 0;
        for (int k = 0; k < 4; k++)
            total += (int'(t_in[k]) + 4 * int'(b_in[k])) * (4 ** k);
        return 17'(total);
    endfunction

    task automatic clear_rows();
        for (int k = 0; k < 4; k++) begin
            t_in[k] = '0;
            b_in[k] = '0;
        end
    endtask

    // Encode x*y as four legal rows: row k value = x * (2-bit digit k of y),
    // split randomly between t and b within their field ranges.
    task automatic encode_xy(input logic [7:0] x, input logic [7:0] y);
        for (int k = 0; k < 4; k++) begin
            int v, bmin, bmax, bsel;
            v    = int'(x) * int'(y[2*k +: 2]);
            bmax = (v / 4 > 127) ? 127 : v / 4;
            bmin = (v > 511) ? (v - 511 + 3) / 4 : 0;
            bsel = int'($urandom_range(bmax, bmin));
            b_in[k] = 7'(bsel);
            t_in[k] = 9'(v - 4 * bsel);
        end
        cur_exp = 17'(int'(x) * int'(y));
    endtask

    // One clock: check outputs at the falling edge, record accepted inputs,
    // then return 1 time unit after the rising edge.
    task automatic tick();
        logic [16:0] e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("q_prod", 32'(prod), 32'(e[15:0]));
                check("q_ovf", 32'(prod_ovf), 32'(e[16]));
            end
        end
        if (stall_prev && out_valid) begin
            check("stall_prod_stable", 32'(prod), 32'(held_prod));
            check("stall_ovf_stable", 32'(prod_ovf), 32'(held_ovf));
        end
        stall_prev = out_valid && !out_ready;
        held_prod  = prod;
        held_ovf   = prod_ovf;
        if (!in_ready) saw_full = 1'b1;
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    // Single vector: accept, confirm no early output, then exact product at N+2.
    task automatic run_single(input string tag, input logic [16:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cur_exp   = model_sum();
        tick();
        check({tag, "_accept"}, 32'(accepted), 32'd1);
        in_valid = 1'b0;
        check({tag, "_no_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_prod"}, 32'(prod), 32'(exp[15:0]));
        check({tag, "_ovf"}, 32'(prod_ovf), 32'(exp[16]));
        tick();
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int idx;
        int n_sent;
        int out_base;

        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        stall_prev = 1'b0;
        saw_full   = 1'b0;
        n_out      = 0;
        cur_exp    = '0;
        clear_rows();

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        check("rst_ovf", 32'(prod_ovf), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed weight checks
        t_in[0] = 9'h001;
        run_single("one", 17'd1);
        clear_rows(); b_in[0] = 7'h40;
        run_single("row0_b", 17'd256);
        clear_rows(); t_in[1] = 9'h003;
        run_single("row1_t", 17'd12);
        clear_rows(); t_in[3] = 9'h100;
        run_single("row3_t", 17'd16384);
        for (int k = 0; k < 4; k++) begin
            t_in[k] = 9'h1FF;
            b_in[k] = 7'h7F;
        end
        run_single("all_ones", 17'd86615);

        // Back-to-back stream of 10 single-row vectors with a stall in cycles 3..6
        idx      = 0;
        saw_full = 1'b0;
        out_base = n_out;
        for (int c = 0; c < 60; c++) begin
            if (idx >= 10 && exp_q.size() == 0) break;
            out_ready = !(c >= 3 && c <= 6);
            clear_rows();
            if (idx < 10) begin
                in_valid = 1'b1;
                t_in[idx % 4] = 9'(idx + 1);
                cur_exp = model_sum();
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (accepted) idx++;
        end
        in_valid = 1'b0;
        check("stream_in_ready_dropped", 32'(saw_full), 32'd1);
        check("stream_all_sent", 32'(idx), 32'd10);
        check("stream_out_count", 32'(n_out - out_base), 32'd10);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two results in flight
        out_ready = 1'b0;
        clear_rows(); t_in[0] = 9'h005;
        in_valid = 1'b1; cur_exp = model_sum();
        tick();
        t_in[0] = 9'h007; cur_exp = model_sum();
        tick();
        in_valid = 1'b0;
        check("inflight_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_prod", 32'(prod), 32'd0);
        check("midrst_ovf", 32'(prod_ovf), 32'd0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_empty", 32'(out_valid), 32'd0);
        clear_rows(); t_in[2] = 9'h001;
        run_single("post_rst", 17'd16);

        // Random multiplications with random back-pressure
        n_sent = 0;
        for (int c = 0; c < 1000 && n_sent < 150; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            in_valid  = ($urandom_range(3, 0) != 0);
            encode_xy(8'($urandom), 8'($urandom));
            tick();
            if (accepted) n_sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("rand_sent", 32'(n_sent), 32'd150);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
